smm_result_drain: RTL

Result drain for the 3x3 systolic matrix multiplier. When the array's accumulators are final, the controller pulses `cap_i`. The block snapshots all nine `2*BW`-bit `Y` values in that cycle and streams them out one element per transfer, in row-major order, over a valid/ready port. Each beat carries row/col indices and a last flag. This is the read side of the array: it frees the array for the next load while results drain at the consumer's pace.

---
 rtl/smm_result_drain.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/smm_result_drain.sv
// Result drain for the 3x3 systolic multiplier: snapshots Y on cap_i and streams it row-major over valid/ready.
// Define SMM_DRAIN_DBUF_EN to add a pending bank that holds one capture arriving mid-stream.
module smm_result_drain #(
    parameter int BW = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cap_i,
    input  logic [2:0][2:0][2*BW-1:0]     Y,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [2*BW-1:0]               m_data,
    output logic [1:0]                    m_row,
    output logic [1:0]                    m_col,
    output logic                          m_last,
    output logic                          busy,
    output logic                          ovf,
    input  logic                          clr_ovf
);

    localparam int DW = 2 * BW;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             idx_q, idx_d;
    logic [1:0]             row_q, row_d;
    logic [1:0]             col_q, col_d;
    logic [8:0][DW-1:0]     active_q, active_d;
    logic                   ovf_q, ovf_d;
    logic                   ovfSet;
    logic                   xfer;
    logic                   lastXfer;
    logic                   pendFull;
    logic [8:0][DW-1:0]     yFlat;

    // Y[r][c] sits at element offset 3*r+c of the packed array, i.e. row-major order.
    assign yFlat = Y;

`ifdef SMM_DRAIN_DBUF_EN
    logic [8:0][DW-1:0]     pend_q, pend_d;
    logic                   pendFull_q, pendFull_d;
    assign pendFull = pendFull_q;
`else
    assign pendFull = 1'b0;
`endif

    assign m_valid  = (state_q == STREAM);
    assign m_data   = m_valid ? active_q[idx_q] : '0;
    assign m_row    = row_q;
    assign m_col    = col_q;
    assign m_last   = m_valid && (idx_q == 4'd8);
    assign busy     = m_valid | pendFull;
    assign ovf      = ovf_q;

    assign xfer     = m_valid & m_ready;
    assign lastXfer = xfer && (idx_q == 4'd8);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        row_d    = row_q;
        col_d    = col_q;
        active_d = active_q;
        ovfSet   = 1'b0;
`ifdef SMM_DRAIN_DBUF_EN
        pend_d     = pend_q;
        pendFull_d = pendFull_q;
`endif

        case (state_q)
            IDLE: begin
                if (cap_i) begin
                    active_d = yFlat;
                    idx_d    = 4'd0;
                    row_d    = 2'd0;
                    col_d    = 2'd0;
                    state_d  = STREAM;
                end
            end

            STREAM: begin
                if (lastXfer) begin
                    // Every outcome of the final transfer rewinds the beat position to (0,0).
                    idx_d = 4'd0;
                    row_d = 2'd0;
                    col_d = 2'd0;
`ifdef SMM_DRAIN_DBUF_EN
                    if (pendFull_q) begin
                        active_d   = pend_q;
                        pend_d     = yFlat;
                        pendFull_d = cap_i;
                    end else if (cap_i) begin
                        active_d = yFlat;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    if (cap_i) begin
                        active_d = yFlat;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end else begin
                    if (xfer) begin
                        idx_d = idx_q + 4'd1;
                        if (col_q == 2'd2) begin
                            col_d = 2'd0;
                            row_d = row_q + 2'd1;
                        end else begin
                            col_d = col_q + 2'd1;
                        end
                    end
                    if (cap_i) begin
`ifdef SMM_DRAIN_DBUF_EN
                        if (!pendFull_q) begin
                            pend_d     = yFlat;
                            pendFull_d = 1'b1;
                        end else begin
                            ovfSet = 1'b1;
                        end
`else
                        ovfSet = 1'b1;
`endif
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A dropped capture in the same cycle as clr_ovf must stay visible.
        if (ovfSet) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= 4'd0;
            row_q    <= 2'd0;
            col_q    <= 2'd0;
            active_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            row_q    <= row_d;
            col_q    <= col_d;
            active_q <= active_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef SMM_DRAIN_DBUF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            pendFull_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pendFull_q <= pendFull_d;
        end
    end
`endif

endmodule
